riscv_32i_data_mem_ctrl: RTL

Parametrised data-memory controller for the RV32I core's load/store path.
- Owns a word-organised RAM and accepts one load/store request at a time over a valid/ready handshake.
- Performs byte-lane steering for SB/SH/SW and sign or zero extension for LB/LH/LW/LBU/LHU.
- Detects illegal-size, misaligned and out-of-range accesses, and returns a fault instead of touching memory.
- Read latency is configurable, so the same block can front block RAM or registered-output RAM.

---
 rtl/riscv_32i_data_mem_ctrl_pkg.sv | 34 +++
 rtl/riscv_32i_data_mem_array.sv | 40 ++++
 rtl/riscv_32i_data_mem_ctrl.sv | 167 ++++++++++++++++
 3 files changed

// File: rtl/riscv_32i_data_mem_ctrl_pkg.sv
// Shared types and defaults for the RV32I data-memory controller and its RAM array.
package riscv_32i_data_mem_ctrl_pkg;

  typedef enum logic [1:0] {
    SIZE_BYTE    = 2'b00,
    SIZE_HALF    = 2'b01,
    SIZE_WORD    = 2'b10,
    SIZE_ILLEGAL = 2'b11
  } mem_size_e;

  typedef enum logic [1:0] {
    FAULT_NONE     = 2'b00,
    FAULT_MISALIGN = 2'b01,
    FAULT_RANGE    = 2'b10,
    FAULT_SIZE     = 2'b11
  } mem_fault_e;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    WAIT = 2'b01,
    RESP = 2'b10
  } mem_state_e;

  localparam int unsigned DATA_MEM_DEPTH        = 1024;
  localparam logic [31:0] DATA_MEM_BASE_ADDR    = 32'h0000_0000;
  localparam int unsigned DATA_MEM_READ_LATENCY = 1;

  // 33 bits wide so the last byte of a window ending at 4 GiB is representable.
  function automatic logic [32:0] data_mem_last_addr(input logic [31:0] base,
                                                     input int unsigned depth);
    return {1'b0, base} + (33'(depth) << 2) - 33'd1;
  endfunction

endpackage

// File: rtl/riscv_32i_data_mem_array.sv
// Word-organised RAM with byte-enable writes and a READ_LATENCY-deep read pipeline.
module riscv_32i_data_mem_array
  import riscv_32i_data_mem_ctrl_pkg::*;
#(
  parameter int unsigned DEPTH        = DATA_MEM_DEPTH,
  parameter int unsigned READ_LATENCY = DATA_MEM_READ_LATENCY,
  localparam int unsigned AW          = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          we_i,
  input  logic [3:0]    be_i,
  input  logic          re_i,
  input  logic [AW-1:0] addr_i,
  input  logic [31:0]   wdata_i,
  output logic [31:0]   rdata_o
);

  logic [31:0] mem_q [DEPTH];
  logic [31:0] rd_pipe_q [READ_LATENCY];

  always_ff @(posedge clk) begin
    if (we_i) begin
      for (int b = 0; b < 4; b++) begin
        if (be_i[b]) mem_q[addr_i][8*b +: 8] <= wdata_i[8*b +: 8];
      end
    end
  end

  // Stage 0 holds its value between reads, so the whole pipe settles on the
  // last read word and the output stays stable while a response is stalled.
  always_ff @(posedge clk) begin
    if (re_i) rd_pipe_q[0] <= mem_q[addr_i];
    for (int s = 1; s < READ_LATENCY; s++) begin
      rd_pipe_q[s] <= rd_pipe_q[s-1];
    end
  end

  assign rdata_o = rd_pipe_q[READ_LATENCY-1];

endmodule

// File: rtl/riscv_32i_data_mem_ctrl.sv
// RV32I load/store controller: access checks, byte-lane steering, load extension and handshake FSM.
module riscv_32i_data_mem_ctrl
  import riscv_32i_data_mem_ctrl_pkg::*;
#(
  parameter int unsigned DEPTH        = DATA_MEM_DEPTH,
  parameter logic [31:0] BASE_ADDR    = DATA_MEM_BASE_ADDR,
  parameter int unsigned READ_LATENCY = DATA_MEM_READ_LATENCY
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_fault,
  output logic [1:0]  rsp_fault_code
);

  localparam int unsigned AW        = $clog2(DEPTH);
  localparam logic [32:0] LAST_ADDR = data_mem_last_addr(BASE_ADDR, DEPTH);
  localparam logic [1:0]  WAIT_INIT = 2'(READ_LATENCY - 1);

  mem_state_e    state_q, state_d;
  logic [1:0]    cnt_q, cnt_d;
  logic          live_q;
  logic          we_q, uns_q;
  mem_size_e     size_q;
  logic [1:0]    off_q;
  mem_fault_e    code_q;

  mem_size_e     size_w;
  mem_fault_e    code_w;
  logic [32:0]   end_w;
  logic [3:0]    be_w;
  logic [31:0]   wdata_w;
  logic [AW-1:0] idx_w;
  logic [31:0]   arr_rdata;
  logic          accept;

  function automatic logic [31:0] load_extend(input logic [31:0] word,
                                              input logic [1:0]  off,
                                              input mem_size_e   size,
                                              input logic        uns);
    logic [7:0]  b;
    logic [15:0] h;
    b = word[{off, 3'b000} +: 8];
    h = off[1] ? word[31:16] : word[15:0];
    case (size)
      SIZE_BYTE: return uns ? {24'b0, b} : {{24{b[7]}}, b};
      SIZE_HALF: return uns ? {16'b0, h} : {{16{h[15]}}, h};
      default:   return word;
    endcase
  endfunction

  assign size_w    = mem_size_e'(req_size);
  assign req_ready = live_q && (state_q == IDLE);
  assign accept    = req_valid && req_ready;
  assign idx_w     = AW'((req_addr - BASE_ADDR) >> 2);

  // Priority: size, then alignment, then range.
  always_comb begin
    code_w = FAULT_NONE;
    case (size_w)
      SIZE_HALF: end_w = {1'b0, req_addr} + 33'd1;
      SIZE_WORD: end_w = {1'b0, req_addr} + 33'd3;
      default:   end_w = {1'b0, req_addr};
    endcase
    if (size_w == SIZE_ILLEGAL) begin
      code_w = FAULT_SIZE;
    end else if ((size_w == SIZE_HALF && req_addr[0]) ||
                 (size_w == SIZE_WORD && req_addr[1:0] != 2'b00)) begin
      code_w = FAULT_MISALIGN;
    end else if (req_addr < BASE_ADDR || end_w > LAST_ADDR) begin
      code_w = FAULT_RANGE;
    end
  end

  always_comb begin
    be_w    = 4'b1111;
    wdata_w = req_wdata;
    case (size_w)
      SIZE_BYTE: begin
        be_w    = 4'b0001 << req_addr[1:0];
        wdata_w = {4{req_wdata[7:0]}};
      end
      SIZE_HALF: begin
        be_w    = req_addr[1] ? 4'b1100 : 4'b0011;
        wdata_w = {2{req_wdata[15:0]}};
      end
      default: ;
    endcase
  end

  riscv_32i_data_mem_array #(
    .DEPTH        (DEPTH),
    .READ_LATENCY (READ_LATENCY)
  ) u_array (
    .clk     (clk),
    .we_i    (accept && req_we && code_w == FAULT_NONE),
    .be_i    (be_w),
    .re_i    (accept && !req_we && code_w == FAULT_NONE),
    .addr_i  (idx_w),
    .wdata_i (wdata_w),
    .rdata_o (arr_rdata)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          if (req_we || code_w != FAULT_NONE || READ_LATENCY == 1) begin
            state_d = RESP;
          end else begin
            state_d = WAIT;
            cnt_d   = WAIT_INIT;
          end
        end
      end
      WAIT: begin
        cnt_d = cnt_q - 2'd1;
        if (cnt_q == 2'd1) state_d = RESP;
      end
      RESP: begin
        if (rsp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= 2'd0;
      live_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      live_q  <= 1'b1;
    end
  end

  // Request attributes needed at response time; outputs are gated by state.
  always_ff @(posedge clk) begin
    if (accept) begin
      we_q   <= req_we;
      uns_q  <= req_unsigned;
      size_q <= size_w;
      off_q  <= req_addr[1:0];
      code_q <= code_w;
    end
  end

  assign rsp_valid      = (state_q == RESP);
  assign rsp_fault      = rsp_valid && (code_q != FAULT_NONE);
  assign rsp_fault_code = rsp_valid ? code_q : FAULT_NONE;
  assign rsp_rdata      = (rsp_valid && !we_q && code_q == FAULT_NONE)
                          ? load_extend(arr_rdata, off_q, size_q, uns_q) : 32'h0;

endmodule
